sparse_mvm_engine: RTL and testbench
====================================

# sparse_mvm_engine

Parametrised sparsity-aware matrix-vector multiply engine: computes y = A·x for an N×N signed matrix A streamed as nonzero (row, col, value) triples and a dense length-N vector x. Generalises the fixed 4×4, 8-bit MVM accelerator with configurable dimension and data width, valid/ready handshakes on both sides, full-precision signed accumulation, and a nonzero counter. Sits between the host-side input pins and the output pins in the top-level tile wrapper.

## Interface
- N, default 4: matrix/vector dimension (N ≥ 2).
- DW, default 8: signed element width for x and A.
- IDX_W, default $clog2(N): row/col index width (derived, not overridden).
- ACC_W, default 2*DW + 2*IDX_W: accumulator/result width (derived).
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begins a job when sampled high in IDLE; ignored elsewhere.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts beat; transfer = in_valid & in_ready.
- in_vec  in  1  1 = vector element beat, 0 = matrix entry beat.
- in_row  in  IDX_W  matrix row (don't-care for vector beats).
- in_col  in  IDX_W  matrix column / vector index.
- in_data  in  DW  signed value.
- in_last  in  1  marks final beat of current load phase.
- out_valid  out  1  result element valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed y[out_idx].
- out_idx  out  IDX_W  result index.
- out_last  out  1  high with out_idx = N-1.
- busy  out  1  high in any state except IDLE.
- nnz_count  out  2*IDX_W+1  nonzero matrix entries accumulated in current/last job.
- err  out  1  sticky protocol error, cleared on start.

## Operation
- States: IDLE → LOAD_VEC → LOAD_MAT → FLUSH → DRAIN → IDLE.
- IDLE: start=1 clears x[], acc[], nnz_count, err; next LOAD_VEC.
- LOAD_VEC: accepted beat with in_vec=1 writes x[in_col]=in_data; unwritten elements stay 0. Accepted beat with in_vec=0 is dropped, sets err. Accepted beat with in_last=1 → LOAD_MAT.
- LOAD_MAT: accepted beat with in_vec=0 and in_data≠0 enters MAC pipeline: stage 1 registers product in_data*x[in_col] (signed, 2*DW) and row; stage 2 adds sign-extended product into acc[row], increments nnz_count. in_data=0 accepted and discarded (no MAC, no count). in_vec=1 beat dropped, sets err. in_last=1 → FLUSH.
- Repeated (row, col) entries are summed. Accumulator wraps modulo 2^ACC_W (cannot overflow for ≤ N² entries of full-scale values).
- Back-to-back beats to the same row require no stall: stage 2 is the sole read-modify-write of acc.
- FLUSH: one cycle, drains stage 2; → DRAIN.
- DRAIN: presents acc[0..N-1] in order; index advances on out_valid & out_ready; handshake with out_last → IDLE.
- rst_n low at any cycle (incl. mid-job): next edge all state to IDLE, x[], acc[], pipeline, counters cleared.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, nnz_count=0, err=0.
- in_ready = 1 exactly in LOAD_VEC and LOAD_MAT; 0 in IDLE, FLUSH, DRAIN. No combinational path in_valid→in_ready.
- start high in IDLE at edge k: busy and in_ready high from cycle k+1.
- Matrix beat accepted at edge k updates acc at edge k+2; last beat at k → FLUSH k+1, out_valid high from k+2.
- out_data/out_idx/out_last registered, held stable while out_valid & !out_ready.
- Final drain handshake at edge m: busy=0, out_valid=0 at cycle m+1; start accepted at edge m+1 earliest.
- Throughput: one input beat per cycle, one output per cycle under out_ready=1.
- Job latency (ready consumer): 1 + V + M + 1 + N cycles for V vector and M matrix beats.

## Structure
- Package sparse_mvm_pkg: state enum type (IDLE, LOAD_VEC, LOAD_MAT, FLUSH, DRAIN), derived-width localparam functions for IDX_W/ACC_W.
- One sub-module: sparse_mac_stage (registered signed multiply + row tag, valid bit); accumulator array and FSM remain in sparse_mvm_engine.
- Top-level tile wrapper remaps pins to this interface for N=4, DW=8.

## Test plan
- Dense 4×4, x=[1,2,3,4], A=identity (4 beats) → y=[1,2,3,4], nnz_count=4, err=0.
- Sparse: x=[-128,127,5,0], entries (0,0,-128),(3,1,127),(0,1,0) → y=[16384,0,0,16129], nnz_count=2.
- Duplicate/back-to-back same row: (2,2,3) twice with x[2]=7, consecutive cycles → y[2]=42, others 0.
- Output backpressure: out_ready toggled 1,0,0,1… → each y[i] held stable while stalled, out_idx 0..3 in order, out_last only at idx 3.
- Protocol error: in_vec=0 beat during LOAD_VEC → dropped, err=1 until next start; result unaffected.
- Reset mid-LOAD_MAT after 2 beats → next cycle busy=0, in_ready=0; new job yields results from new data only.

Source files
------------

// File: rtl/sparse_mvm_pkg.sv
// sparse_mvm_pkg
//   Shared types and width helpers for the sparse matrix-vector engine.
//   state_t      : engine control states
//   calc_idx_w() : index width for an N-element dimension
//   calc_acc_w() : full-precision accumulator width
package sparse_mvm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_VEC,
      LOAD_MAT,
      FLUSH,
      DRAIN
   } state_t;

   function automatic int calc_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Sum of up to N*N full-scale products: 2*DW product bits plus
   // log2(N*N) growth bits.
   function automatic int calc_acc_w(input int dw, input int n);
      return 2 * dw + 2 * calc_idx_w(n);
   endfunction

endpackage

// File: rtl/sparse_mac_stage.sv
// sparse_mac_stage
//   First MAC pipeline stage: registers a signed product and the row it
//   belongs to, with a valid flag.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : capture a new product this cycle
//   a, b       : signed operands (matrix value, vector element)
//   row        : destination row tag
//   vld        : product/row registers hold a live entry
//   prod       : registered signed product (2*DW)
//   prod_row   : registered row tag
module sparse_mac_stage #(
   parameter int DW    = 8,
   parameter int IDX_W = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   input  logic [IDX_W-1:0]        row,
   output logic                    vld,
   output logic signed [2*DW-1:0]  prod,
   output logic [IDX_W-1:0]        prod_row
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld      <= 1'b0;
         prod     <= '0;
         prod_row <= '0;
      end else begin
         vld <= en;
         if (en) begin
            prod     <= (2*DW)'(a) * (2*DW)'(b);
            prod_row <= row;
         end
      end
   end

endmodule

// File: rtl/sparse_mvm_engine.sv
// sparse_mvm_engine
//   y = A*x for an N x N signed matrix streamed as nonzero (row,col,value)
//   triples after a dense vector load. Results drained in index order.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : begin a job (IDLE only)
//   in_valid/in_ready : input beat handshake
//   in_vec            : 1 = vector element, 0 = matrix entry
//   in_row, in_col    : matrix coordinates / vector index
//   in_data           : signed element value
//   in_last           : last beat of the current load phase
//   out_valid/ready   : result handshake
//   out_data, out_idx : y[out_idx]
//   out_last          : final result element
//   busy              : not IDLE
//   nnz_count         : nonzero entries accumulated this/last job
//   err               : sticky protocol error, cleared on start
module sparse_mvm_engine
   import sparse_mvm_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int DW    = 8,
   localparam int IDX_W = calc_idx_w(N),
   localparam int ACC_W = calc_acc_w(DW, N),
   localparam int CNT_W = 2 * IDX_W + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_vec,
   input  logic [IDX_W-1:0]        in_row,
   input  logic [IDX_W-1:0]        in_col,
   input  logic signed [DW-1:0]    in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    busy,
   output logic [CNT_W-1:0]        nnz_count,
   output logic                    err
);

   state_t state, state_nxt;

   logic signed [DW-1:0]    x       [N];
   logic signed [ACC_W-1:0] acc     [N];
   logic signed [ACC_W-1:0] acc_nxt [N];

   logic                    in_fire, out_fire, job_start;
   logic                    vec_wr, mat_en, proto_err;
   logic signed [DW-1:0]    x_sel;
   logic                    mac_vld;
   logic signed [2*DW-1:0]  mac_prod;
   logic [IDX_W-1:0]        mac_row;
   logic [IDX_W-1:0]        idx_inc;

   assign in_ready  = (state == LOAD_VEC) || (state == LOAD_MAT);
   assign busy      = (state != IDLE);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign job_start = (state == IDLE) && start;
   assign idx_inc   = out_idx + IDX_W'(1);

   assign vec_wr    = in_fire && (state == LOAD_VEC) && in_vec && (int'(in_col) < N);
   // Zero-valued matrix entries contribute nothing: skip the MAC and the count.
   assign mat_en    = in_fire && (state == LOAD_MAT) && !in_vec && (in_data != '0);
   assign proto_err = in_fire && (((state == LOAD_VEC) && !in_vec) ||
                                  ((state == LOAD_MAT) &&  in_vec));
   assign x_sel     = (int'(in_col) < N) ? x[in_col] : '0;

   //------------------------------------------------------------------
   // Control FSM
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start)              state_nxt = LOAD_VEC;
         LOAD_VEC: if (in_fire && in_last) state_nxt = LOAD_MAT;
         LOAD_MAT: if (in_fire && in_last) state_nxt = FLUSH;
         FLUSH:                            state_nxt = DRAIN;
         DRAIN:    if (out_fire && out_last) state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   //------------------------------------------------------------------
   // MAC pipeline: stage 1 in the sub-module, stage 2 is the only
   // read-modify-write of acc, so same-row beats never need a stall.
   //------------------------------------------------------------------
   sparse_mac_stage #(.DW(DW), .IDX_W(IDX_W)) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (mat_en),
      .a        (in_data),
      .b        (x_sel),
      .row      (in_row),
      .vld      (mac_vld),
      .prod     (mac_prod),
      .prod_row (mac_row)
   );

   always_comb begin
      for (int i = 0; i < N; i++) acc_nxt[i] = acc[i];
      if (mac_vld && (int'(mac_row) < N))
         acc_nxt[mac_row] = acc[mac_row] +
                            {{(ACC_W-2*DW){mac_prod[2*DW-1]}}, mac_prod};
   end

   always_ff @(posedge clk) begin
      if (!rst_n || job_start) begin
         for (int i = 0; i < N; i++) begin
            x[i]   <= '0;
            acc[i] <= '0;
         end
         nnz_count <= '0;
         err       <= 1'b0;
      end else begin
         if (vec_wr) x[in_col] <= in_data;
         for (int i = 0; i < N; i++) acc[i] <= acc_nxt[i];
         if (mac_vld)   nnz_count <= nnz_count + CNT_W'(1);
         if (proto_err) err       <= 1'b1;
      end
   end

   //------------------------------------------------------------------
   // Result registers. The first element is loaded from acc_nxt so the
   // final stage-2 add landing on the FLUSH edge is included.
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else if (state == FLUSH) begin
         out_valid <= 1'b1;
         out_idx   <= '0;
         out_data  <= acc_nxt[0];
         out_last  <= 1'b0;
      end else if ((state == DRAIN) && out_fire) begin
         if (out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            out_idx  <= idx_inc;
            out_data <= acc[idx_inc];
            out_last <= (idx_inc == IDX_W'(N-1));
         end
      end
   end

endmodule

// File: tb/tb_sparse_mvm_engine.sv
// tb_sparse_mvm_engine
//   Directed jobs; expected y vectors are pushed into a scoreboard queue
//   and a negedge monitor compares every valid output cycle against the
//   queue head, popping on handshake.
module tb_sparse_mvm_engine;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int IDX_W = 2;
   localparam int ACC_W = 20;
   localparam int CNT_W = 5;

   logic                    clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic                    in_valid = 1'b0, in_vec = 1'b0, in_last = 1'b0;
   logic                    out_ready = 1'b1;
   logic [IDX_W-1:0]        in_row = '0, in_col = '0;
   logic signed [DW-1:0]    in_data = '0;
   logic                    in_ready, out_valid, out_last, busy, err;
   logic signed [ACC_W-1:0] out_data;
   logic [IDX_W-1:0]        out_idx;
   logic [CNT_W-1:0]        nnz_count;

   int       tests = 0, fails = 0;
   bit       bp_mode = 1'b0;
   int       bp_cnt = 0;
   bit [3:0] bp_pat = 4'b1001;   // out_ready sequence 1,0,0,1,...

   typedef struct {
      logic signed [ACC_W-1:0] data;
      logic [IDX_W-1:0]        idx;
      logic                    last;
   } exp_t;
   exp_t exp_q[$];

   sparse_mvm_engine #(.N(N), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .in_row(in_row), .in_col(in_col), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy),
      .nnz_count(nnz_count), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // out_ready driver
   always @(posedge clk) begin
      #1;
      if (bp_mode) begin
         out_ready = bp_pat[bp_cnt % 4];
         bp_cnt++;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Monitor: every valid cycle must match the queue head (also proves
   // the output is held stable while stalled).
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: idx %0d data %0d with empty queue", out_idx, out_data);
         end else begin
            check("out_data", out_data, exp_q[0].data);
            check("out_idx",  out_idx,  exp_q[0].idx);
            check("out_last", out_last, exp_q[0].last);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("in_ready_after_start", in_ready, 1);
   endtask

   task automatic beat(input bit vec, input int row, input int col,
                       input int data, input bit last);
      bit ok = 1'b0;
      in_valid = 1'b1; in_vec = vec; in_last = last;
      in_row = IDX_W'(row); in_col = IDX_W'(col); in_data = DW'(data);
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = in_ready;
         step();
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL beat_accept: in_ready stayed %0b", in_ready);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_y(input int y0, input int y1, input int y2, input int y3);
      int y[4];
      y = '{y0, y1, y2, y3};
      for (int i = 0; i < N; i++)
         exp_q.push_back(exp_t'{data: ACC_W'(y[i]), idx: IDX_W'(i), last: (i == N-1)});
   endtask

   task automatic wait_done(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (!busy && exp_q.size() == 0) done = 1'b1;
         else step();
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL %s_done: busy=%0b pending=%0d", name, busy, exp_q.size());
      end
   endtask

   initial begin
      // reset state
      step(); step();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_nnz", nnz_count, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      step();

      // identity, x=[1,2,3,4]
      do_start();
      for (int i = 0; i < N; i++) beat(1'b1, 0, i, i + 1, i == N-1);
      expect_y(1, 2, 3, 4);
      for (int i = 0; i < N; i++) beat(1'b0, i, i, 1, i == N-1);
      wait_done("identity");
      check("identity_nnz", nnz_count, 4);
      check("identity_err", err, 0);

      // sparse with full-scale values and a zero entry
      do_start();
      beat(1'b1, 0, 0, -128, 1'b0);
      beat(1'b1, 0, 1,  127, 1'b0);
      beat(1'b1, 0, 2,    5, 1'b0);
      beat(1'b1, 0, 3,    0, 1'b1);
      expect_y(16384, 0, 0, 16129);
      beat(1'b0, 0, 0, -128, 1'b0);
      beat(1'b0, 3, 1,  127, 1'b0);
      beat(1'b0, 0, 1,    0, 1'b1);
      wait_done("sparse");
      check("sparse_nnz", nnz_count, 2);

      // back-to-back duplicate entry on the same row
      do_start();
      beat(1'b1, 0, 2, 7, 1'b1);
      expect_y(0, 0, 42, 0);
      beat(1'b0, 2, 2, 3, 1'b0);
      beat(1'b0, 2, 2, 3, 1'b1);
      wait_done("dup");
      check("dup_nnz", nnz_count, 2);

      // output backpressure, diag(2) * [10,-20,30,-40]
      bp_mode = 1'b1;
      bp_cnt  = 0;
      do_start();
      beat(1'b1, 0, 0,  10, 1'b0);
      beat(1'b1, 0, 1, -20, 1'b0);
      beat(1'b1, 0, 2,  30, 1'b0);
      beat(1'b1, 0, 3, -40, 1'b1);
      expect_y(20, -40, 60, -80);
      for (int i = 0; i < N; i++) beat(1'b0, i, i, 2, i == N-1);
      wait_done("backpressure");
      bp_mode = 1'b0;
      step();

      // protocol error: matrix beat during vector load is dropped
      do_start();
      beat(1'b1, 0, 0, 5, 1'b0);
      beat(1'b0, 0, 2, 9, 1'b0);
      check("err_set", err, 1);
      beat(1'b1, 0, 1, 2, 1'b1);
      expect_y(0, 6, 0, 0);
      beat(1'b0, 1, 1, 3, 1'b0);
      beat(1'b0, 0, 2, 1, 1'b1);
      wait_done("proto_err");
      check("err_sticky", err, 1);
      check("proto_nnz", nnz_count, 2);

      // reset in the middle of a matrix load
      do_start();
      check("err_cleared_on_start", err, 0);
      for (int i = 0; i < N; i++) beat(1'b1, 0, i, 1, i == N-1);
      beat(1'b0, 0, 0, 5, 1'b0);
      beat(1'b0, 1, 1, 5, 1'b0);
      rst_n = 1'b0;
      step();
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_nnz", nnz_count, 0);
      check("midrst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      step();
      do_start();
      beat(1'b1, 0, 0, 2, 1'b1);
      expect_y(6, 0, 0, 0);
      beat(1'b0, 0, 0, 3, 1'b1);
      wait_done("after_reset");
      check("after_reset_nnz", nnz_count, 1);

      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
